uart_rx_scheduler: RTL and testbench

- Controller that drains the UART receive FIFO into a valid/ready byte stream.
- Sits between the receiver's FIFO outputs (rf_count, rf_data_out, rf_pop) and the consumer (DMA or CPU shim).
- Drains in bursts: a burst starts when the FIFO reaches a programmable trigger level or when the character-timeout counter expires.
- Drives RTS-style flow control with hysteresis and reports per-word parity/framing errors.

---
 rtl/uart_rx_scheduler.sv | 216 +++++++++++++++++++++
 tb/tb_uart_rx_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_scheduler.sv
// uart_rx_scheduler
// Drains the UART receive FIFO into a valid/ready byte stream.
// A burst starts when the FIFO reaches the programmed trigger level or when
// the character timeout expires. Once started, it continues until the FIFO is empty.
// rts_o gives registered flow control with hysteresis. Errored words are
// reported on err_o and counted in the saturating err_cnt.
// Optional build macro: UART_RX_ERR_DROP_EN. When it is defined, errored words
// are popped and counted but never presented downstream.
module uart_rx_scheduler #(
  parameter int DATA_W = 10,
  parameter int CNT_W  = 5,
  parameter int HI_WM  = 14,
  parameter int LO_WM  = 8
) (
  input  logic              clk,
  input  logic              wb_rst_i,
  input  logic [CNT_W-1:0]  rf_count,
  input  logic [DATA_W-1:0] rf_data_out,
  output logic              rf_pop,
  input  logic [9:0]        counter_t,
  input  logic [1:0]        burst_lvl,
  input  logic              rx_flush,
  output logic [7:0]        m_data,
  output logic              m_perr,
  output logic              m_ferr,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              rts_o,
  output logic              err_o,
  output logic [7:0]        err_cnt
);

  localparam logic [CNT_W-1:0] HI_LVL = CNT_W'(HI_WM);
  localparam logic [CNT_W-1:0] LO_LVL = CNT_W'(LO_WM);
  localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};

`ifdef UART_RX_ERR_DROP_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_HOLD = 2'b01,
    S_DROP = 2'b10
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_HOLD = 2'b01
  } state_t;
`endif

  // FIFO occupancy that fires a burst for each trigger-level code
  function automatic logic [CNT_W-1:0] trig_level(input logic [1:0] lvl);
    logic [CNT_W-1:0] thr;
    case (lvl)
      2'b00:   thr = CNT_W'(1);
      2'b01:   thr = CNT_W'(4);
      2'b10:   thr = CNT_W'(8);
      2'b11:   thr = CNT_W'(14);
      default: thr = CNT_W'(1);
    endcase
    return thr;
  endfunction

  // A FIFO word is errored if either its parity or its framing flag is set
  function automatic logic word_err(input logic [DATA_W-1:0] w);
    return w[1] | w[0];
  endfunction

  // Counter increment that sticks at all-ones
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

  state_t state_r;
  state_t state_n;
  logic burst_active;
  logic burst_n;
  logic pop_n;
  logic valid_n;
  logic [7:0] data_n;
  logic perr_n;
  logic ferr_n;
  logic err_n;
  logic [7:0] cnt_n;
  logic rts_n;
  logic trig;
  logic count_nz;
  logic cap_err;

  // Burst start condition from occupancy, timeout and burst continuation
  always_comb begin
    count_nz = (rf_count != ZERO_CNT);
    cap_err  = word_err(rf_data_out);
    trig     = (rf_count >= trig_level(burst_lvl))
             | (count_nz & (counter_t == 10'd0))
             | (burst_active & count_nz);
  end

  // RTS hysteresis: drop at the high watermark, restore at the low one
  always_comb begin
    if (rf_count >= HI_LVL) begin
      rts_n = 1'b0;
    end else if (rf_count <= LO_LVL) begin
      rts_n = 1'b1;
    end else begin
      rts_n = rts_o;
    end
  end

  // Next-state and output decode; flush overrides all normal transitions
  always_comb begin
    state_n = state_r;
    pop_n   = 1'b0;
    valid_n = m_valid;
    data_n  = m_data;
    perr_n  = m_perr;
    ferr_n  = m_ferr;
    err_n   = 1'b0;
    cnt_n   = err_cnt;
    burst_n = burst_active;
    if (rx_flush) begin
      state_n = S_IDLE;
      valid_n = 1'b0;
      burst_n = 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (trig) begin
            pop_n   = 1'b1;
            burst_n = 1'b1;
            err_n   = cap_err;
            if (cap_err) begin
              cnt_n = sat_inc(err_cnt);
            end else begin
              cnt_n = err_cnt;
            end
`ifdef UART_RX_ERR_DROP_EN
            if (cap_err) begin
              state_n = S_DROP;
              valid_n = 1'b0;
            end else begin
              state_n = S_HOLD;
              valid_n = 1'b1;
              data_n  = rf_data_out[9:2];
              perr_n  = rf_data_out[1];
              ferr_n  = rf_data_out[0];
            end
`else
            state_n = S_HOLD;
            valid_n = 1'b1;
            data_n  = rf_data_out[9:2];
            perr_n  = rf_data_out[1];
            ferr_n  = rf_data_out[0];
`endif
          end else if (!count_nz) begin
            burst_n = 1'b0;
          end else begin
            burst_n = burst_active;
          end
        end
        S_HOLD: begin
          // rf_pop has already been issued on entry; wait for the consumer
          if (m_valid && m_ready) begin
            valid_n = 1'b0;
            state_n = S_IDLE;
          end else begin
            state_n = S_HOLD;
          end
        end
`ifdef UART_RX_ERR_DROP_EN
        S_DROP: begin
          state_n = S_IDLE;
          valid_n = 1'b0;
        end
`endif
        default: begin
          state_n = S_IDLE;
          valid_n = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      state_r      <= S_IDLE;
      rf_pop       <= 1'b0;
      m_valid      <= 1'b0;
      m_data       <= 8'h00;
      m_perr       <= 1'b0;
      m_ferr       <= 1'b0;
      rts_o        <= 1'b1;
      err_o        <= 1'b0;
      err_cnt      <= 8'h00;
      burst_active <= 1'b0;
    end else begin
      state_r      <= state_n;
      rf_pop       <= pop_n;
      m_valid      <= valid_n;
      m_data       <= data_n;
      m_perr       <= perr_n;
      m_ferr       <= ferr_n;
      rts_o        <= rts_n;
      err_o        <= err_n;
      err_cnt      <= cnt_n;
      burst_active <= burst_n;
    end
  end

endmodule

// File: tb/tb_uart_rx_scheduler.sv
// Testbench for uart_rx_scheduler.
// The bench contains a FIFO model that answers rf_pop. Each pushed word
// goes into an expected-output queue. A monitor runs on the falling edge
// and compares every accepted output against the head of that queue. It
// also tracks RTS hysteresis, pop sanity and error counting against simple
// occupancy rules.
module tb_uart_rx_scheduler;

`ifdef UART_RX_ERR_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       wb_rst_i;
  logic [4:0] rf_count;
  logic [9:0] rf_data_out;
  logic       rf_pop;
  logic [9:0] counter_t;
  logic [1:0] burst_lvl;
  logic       rx_flush;
  logic [7:0] m_data;
  logic       m_perr;
  logic       m_ferr;
  logic       m_valid;
  logic       m_ready;
  logic       rts_o;
  logic       err_o;
  logic [7:0] err_cnt;

  uart_rx_scheduler dut (
    .clk(clk), .wb_rst_i(wb_rst_i), .rf_count(rf_count), .rf_data_out(rf_data_out),
    .rf_pop(rf_pop), .counter_t(counter_t), .burst_lvl(burst_lvl), .rx_flush(rx_flush),
    .m_data(m_data), .m_perr(m_perr), .m_ferr(m_ferr), .m_valid(m_valid),
    .m_ready(m_ready), .rts_o(rts_o), .err_o(err_o), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  logic [9:0] fifo[$];
  logic [9:0] exp_q[$];
  int acc_cyc[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_pops = 0;
  int n_acc = 0;
  int n_errp = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  bit pop_pend = 1'b0;
  bit rts_exp = 1'b1;
  int err_exp = 0;
  bit pop_prev = 1'b0;
  bit stall_prev = 1'b0;
  bit excuse_prev = 1'b0;
  logic [9:0] held_w = 10'h0;

  function automatic bit is_err(input logic [9:0] w);
    return (w[1] | w[0]);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic drive();
    rf_count    = 5'(fifo.size());
    rf_data_out = (fifo.size() != 0) ? fifo[0] : 10'h000;
  endtask

  task automatic push_word(input logic [9:0] w);
    if (fifo.size() < DEPTH) begin
      fifo.push_back(w);
      if (!(DROP && is_err(w))) exp_q.push_back(w);
    end
    drive();
  endtask

  function automatic logic [9:0] good_word();
    logic [7:0] d;
    d = 8'($urandom);
    return {d, 2'b00};
  endfunction

  function automatic logic [9:0] bad_word();
    logic [7:0] d;
    logic [1:0] f;
    d = 8'($urandom);
    f = 2'($urandom_range(1, 3));
    return {d, f};
  endfunction

  // One clock: the pop seen on the last falling edge takes effect after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (pop_pend && fifo.size() != 0) fifo.delete(0);
    drive();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      tick();
      done = (fifo.size() == 0) && (m_valid === 1'b0) && (exp_q.size() == 0);
    end
    check({name, "_timeout"}, {31'd0, done}, 32'd1);
    ticks(2);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_m_valid"}, {31'd0, m_valid}, 32'd0);
    check({tag, "_rf_pop"}, {31'd0, rf_pop}, 32'd0);
    check({tag, "_m_data"}, {24'd0, m_data}, 32'd0);
    check({tag, "_flags"}, {30'd0, m_perr, m_ferr}, 32'd0);
    check({tag, "_err_o"}, {31'd0, err_o}, 32'd0);
    check({tag, "_err_cnt"}, {24'd0, err_cnt}, 32'd0);
    check({tag, "_rts_o"}, {31'd0, rts_o}, 32'd1);
  endtask

  // Monitor: scoreboard compare, RTS model, pop and error accounting
  always @(negedge clk) begin
    pop_pend = (rf_pop === 1'b1);
    if (mon_en) begin
      logic [9:0] head;
      logic [9:0] word;
      bit cap_err;
      cyc++;
      head = (fifo.size() != 0) ? fifo[0] : 10'h000;
      word = {m_data, m_perr, m_ferr};
      cap_err = (rf_pop === 1'b1) && (fifo.size() != 0) && is_err(head);
      check("rts_o", {31'd0, rts_o}, {31'd0, rts_exp});
      if (rf_pop === 1'b1) begin
        n_pops++;
        check("pop_nonempty", {31'd0, fifo.size() != 0}, 32'd1);
        check("pop_single_cycle", {31'd0, pop_prev}, 32'd0);
        if (cap_err && err_exp < 255) err_exp++;
      end
      check("err_o", {31'd0, err_o}, {31'd0, cap_err});
      if (err_o === 1'b1) n_errp++;
      check("err_cnt", {24'd0, err_cnt}, 32'(err_exp));
      if (stall_prev && !excuse_prev) begin
        check("hold_valid", {31'd0, m_valid}, 32'd1);
        check("hold_data", {22'd0, word}, {22'd0, held_w});
      end
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        n_acc++;
        acc_cyc.push_back(cyc);
        check("word_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          check("word", {22'd0, word}, {22'd0, exp_q[0]});
          exp_q.delete(0);
        end
      end else if (m_valid === 1'b1 && (rx_flush === 1'b1 || wb_rst_i === 1'b1)) begin
        if (exp_q.size() != 0) exp_q.delete(0);
      end
      stall_prev  = (m_valid === 1'b1) && (m_ready !== 1'b1);
      held_w      = word;
      excuse_prev = (rx_flush === 1'b1) || (wb_rst_i === 1'b1);
      pop_prev    = (rf_pop === 1'b1);
      if (wb_rst_i === 1'b1) rts_exp = 1'b1;
      else if (rf_count >= 5'd14) rts_exp = 1'b0;
      else if (rf_count <= 5'd8) rts_exp = 1'b1;
      if (wb_rst_i === 1'b1) err_exp = 0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int a0;
    int e0;
    int c0;
    int pushed;
    wb_rst_i  = 1'b1;
    rx_flush  = 1'b0;
    m_ready   = 1'b0;
    burst_lvl = 2'b00;
    counter_t = 10'd500;
    drive();
    tick();
    mon_en = 1'b1;
    tick();
    check_reset("reset");
    wb_rst_i = 1'b0;
    ticks(2);

    // Errored word 0x3FD: one err_o pulse, err_cnt 1
    m_ready = 1'b1;
    p0 = n_pops; a0 = n_acc; e0 = n_errp;
    push_word(10'h3FD);
    ticks(6);
    check("errword_pulse", 32'(n_errp - e0), 32'd1);
    check("errword_cnt", {24'd0, err_cnt}, 32'd1);
    check("errword_pops", 32'(n_pops - p0), 32'd1);
    check("errword_presented", 32'(n_acc - a0), DROP ? 32'd0 : 32'd1);

    // Level 4: nothing at 3 words, back-to-back drain at 4
    burst_lvl = 2'b01;
    p0 = n_pops;
    for (int i = 0; i < 3; i++) push_word(good_word());
    ticks(10);
    check("no_pop_below_lvl", 32'(n_pops - p0), 32'd0);
    acc_cyc.delete();
    push_word(good_word());
    wait_drain("burst4", 40);
    check("burst4_count", 32'(acc_cyc.size()), 32'd4);
    if (acc_cyc.size() == 4) begin
      for (int i = 1; i < 4; i++) check("b2b_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd2);
    end
    ticks(3);
    p0 = n_pops;
    push_word(good_word());
    ticks(8);
    check("burst_cleared", 32'(n_pops - p0), 32'd0);

    // Level 14 with two words: only the timeout drains them
    burst_lvl = 2'b11;
    push_word(good_word());
    ticks(4);
    check("no_pop_lvl14", 32'(n_pops - p0), 32'd0);
    counter_t = 10'd0;
    wait_drain("timeout_drain", 20);
    ticks(5);
    check("timeout_pops", 32'(n_pops - p0), 32'd2);
    counter_t = 10'd500;

    // Consumer stall: one pop, data held, accepted when ready returns
    burst_lvl = 2'b00;
    m_ready = 1'b0;
    p0 = n_pops;
    push_word(good_word());
    tick();
    check("latency_valid", {31'd0, m_valid}, 32'd1);
    ticks(10);
    check("stall_single_pop", 32'(n_pops - p0), 32'd1);
    check("stall_valid", {31'd0, m_valid}, 32'd1);
    m_ready = 1'b1;
    ticks(2);
    check("stall_drained", 32'(exp_q.size()), 32'd0);

    // Flush in the second hold cycle discards the held word
    m_ready = 1'b0;
    push_word(good_word());
    ticks(2);
    c0 = int'(err_cnt);
    a0 = n_acc;
    rx_flush = 1'b1;
    tick();
    rx_flush = 1'b0;
    check("flush_valid", {31'd0, m_valid}, 32'd0);
    check("flush_errcnt", {24'd0, err_cnt}, 32'(c0));
    check("flush_discarded", 32'(exp_q.size()), 32'd0);
    m_ready = 1'b1;
    ticks(3);
    check("flush_no_replay", 32'(n_acc - a0), 32'd0);

    // Occupancy ramp to 15 with a stalled consumer, then drain
    m_ready = 1'b0;
    burst_lvl = 2'b11;
    for (int i = 0; i < 16; i++) begin
      push_word(good_word());
      tick();
    end
    ticks(2);
    check("rts_low_full", {31'd0, rts_o}, 32'd0);
    m_ready = 1'b1;
    wait_drain("ramp_drain", 80);
    check("rts_high_empty", {31'd0, rts_o}, 32'd1);

    // Reset in the middle of a burst
    burst_lvl = 2'b00;
    for (int i = 0; i < 6; i++) push_word(good_word());
    ticks(3);
    wb_rst_i = 1'b1;
    tick();
    check_reset("midreset");
    wb_rst_i = 1'b0;
    wait_drain("post_reset_drain", 40);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 3) == 0) push_word(bad_word());
        else push_word(good_word());
      end
      m_ready   = ($urandom_range(0, 9) < 7);
      counter_t = ($urandom_range(0, 9) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
      if ($urandom_range(0, 99) == 0) burst_lvl = 2'($urandom);
      rx_flush  = ($urandom_range(0, 49) == 0);
      tick();
    end
    rx_flush = 1'b0;
    m_ready = 1'b1;
    counter_t = 10'd0;
    wait_drain("random_drain", 200);

    // Error counter saturation
    burst_lvl = 2'b00;
    counter_t = 10'd500;
    pushed = 0;
    for (int i = 0; i < 1500 && pushed < 260; i++) begin
      if (fifo.size() < 8) begin
        push_word(bad_word());
        pushed++;
      end
      tick();
    end
    wait_drain("sat_drain", 100);
    check("err_cnt_sat", {24'd0, err_cnt}, 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
